mod_counter_ctrl: RTL and testbench

MOD_COUNTER_CTRL -- requirements
Module: mod_counter_ctrl

---
 rtl/mod_counter_ctrl_if.sv | 27 ++
 rtl/mod_counter_ctrl.sv | 134 +++++++++++++
 tb/tb_mod_counter_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mod_counter_ctrl_if.sv
// rtl/mod_counter_ctrl_if.sv - control/status bundle between run controller and T-FF counter
interface mod_counter_ctrl_if #(
  parameter int WIDTH = 3
);
  logic             start;
  logic             pause;
  logic             abort;
  logic [3:0]       mod_val;
  logic [3:0]       num_wraps;
  logic [WIDTH-1:0] q_in;
  logic [WIDTH-1:0] t;
  logic             cnt_clr;
  logic             busy;
  logic             tc;
  logic             done;
  logic [3:0]       wrap_cnt;

  modport master (
    output start, pause, abort, mod_val, num_wraps, q_in,
    input  t, cnt_clr, busy, tc, done, wrap_cnt
  );

  modport slave (
    input  start, pause, abort, mod_val, num_wraps, q_in,
    output t, cnt_clr, busy, tc, done, wrap_cnt
  );
endinterface

// File: rtl/mod_counter_ctrl.sv
// rtl/mod_counter_ctrl.sv - run controller driving an external T-flip-flop mod-M counter
module mod_counter_ctrl #(
  parameter int WIDTH = 3
) (
  input  logic              clk,
  input  logic              rst,
  mod_counter_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_RUN   = 3'd2,
    S_PAUSE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t           state, state_n;

  logic [3:0]       mod_lat;
  logic [3:0]       nw_lat;
  logic [3:0]       mod_clamped;
  logic [3:0]       q_ext;
  logic [3:0]       m_last;
  logic [3:0]       wrap_inc;
  logic [WIDTH-1:0] q_inc;
  logic [WIDTH-1:0] t_c;
  logic             wrap_ev;
  logic             clr_ev;
  logic             latch;

  logic             cnt_clr_r;
  logic             busy_r;
  logic             tc_r;
  logic             done_r;
  logic [3:0]       wrap_cnt_r;

  assign q_ext    = 4'(bus.q_in);
  assign q_inc    = bus.q_in + WIDTH'(1);
  assign m_last   = mod_lat - 4'd1;
  assign wrap_inc = wrap_cnt_r + 4'd1;

  assign bus.t        = t_c;
  assign bus.cnt_clr  = cnt_clr_r;
  assign bus.busy     = busy_r;
  assign bus.tc       = tc_r;
  assign bus.done     = done_r;
  assign bus.wrap_cnt = wrap_cnt_r;

  // Keep the requested modulus inside the range a 3-bit counter can realise.
  always_comb begin
    mod_clamped = bus.mod_val;
    if (bus.mod_val < 4'd2) mod_clamped = 4'd2;
    else if (bus.mod_val > 4'd8) mod_clamped = 4'd8;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  // Next state and toggle enables; PAUSE with pause released counts like RUN so no cycle is lost.
  always_comb begin
    state_n = state;
    t_c     = '0;
    wrap_ev = 1'b0;
    clr_ev  = 1'b0;
    latch   = 1'b0;
    case (state)
      S_IDLE: begin
        if (!bus.abort && !bus.pause && bus.start) begin
          state_n = S_CLEAR;
          latch   = 1'b1;
        end
      end
      S_CLEAR: begin
        if (bus.abort) begin
          state_n = S_IDLE;
          clr_ev  = 1'b1;
        end else begin
          state_n = S_RUN;
        end
      end
      S_RUN, S_PAUSE: begin
        if (bus.abort) begin
          state_n = S_IDLE;
          clr_ev  = 1'b1;
        end else if (bus.pause) begin
          state_n = S_PAUSE;
        end else begin
          state_n = S_RUN;
          if (q_ext == m_last) begin
            t_c     = bus.q_in;
            wrap_ev = 1'b1;
            if (nw_lat != 4'd0 && wrap_inc == nw_lat) state_n = S_DONE;
          end else if (q_ext > m_last) begin
            t_c = bus.q_in;
          end else begin
            t_c = bus.q_in ^ q_inc;
          end
        end
      end
      S_DONE: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Registered status outputs and run parameters latched at start.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_clr_r  <= 1'b1;
      busy_r     <= 1'b0;
      tc_r       <= 1'b0;
      done_r     <= 1'b0;
      wrap_cnt_r <= 4'd0;
      mod_lat    <= 4'd2;
      nw_lat     <= 4'd0;
    end else begin
      cnt_clr_r <= clr_ev || (state_n == S_CLEAR);
      busy_r    <= (state_n == S_CLEAR) || (state_n == S_RUN) || (state_n == S_PAUSE);
      tc_r      <= wrap_ev;
      done_r    <= (state == S_DONE);
      if (latch) begin
        wrap_cnt_r <= 4'd0;
        mod_lat    <= mod_clamped;
        nw_lat     <= bus.num_wraps;
      end else if (wrap_ev) begin
        wrap_cnt_r <= wrap_inc;
      end
    end
  end

endmodule

// File: tb/tb_mod_counter_ctrl.sv
// tb/tb_mod_counter_ctrl.sv - randomized self-checking bench for mod_counter_ctrl
module tb_mod_counter_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  logic [2:0] q_cnt = 3'd0;
  logic       load_q = 1'b0;
  logic [2:0] load_val = 3'd0;

  mod_counter_ctrl_if #(.WIDTH(3)) bus ();

  mod_counter_ctrl #(.WIDTH(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // External T-flip-flop counter with synchronous clear and a bench-side load for forcing states.
  always @(posedge clk) begin
    if (load_q)           q_cnt <= load_val;
    else if (bus.cnt_clr) q_cnt <= 3'd0;
    else                  q_cnt <= q_cnt ^ bus.t;
  end
  assign bus.q_in = q_cnt;

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.start = 1'b0; bus.pause = 1'b0; bus.abort = 1'b0;
    bus.mod_val = 4'd0; bus.num_wraps = 4'd0;
  endtask

  task automatic test_reset();
    logic [7:0] obs;
    rst = 1'b1;
    idle_inputs();
    cycle(); cycle();
    rst = 1'b0; #1;
    obs = {bus.busy, bus.tc, bus.done, bus.cnt_clr, bus.wrap_cnt};
    n_tests++;
    if (obs !== 8'b0001_0000 || bus.t !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_state got=%b t=%b exp=00010000 t=000", obs, bus.t);
    end
    cycle(); #1;
    n_tests++;
    if (bus.cnt_clr !== 1'b0 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_clr_one_cycle got clr=%b busy=%b exp 0 0", bus.cnt_clr, bus.busy);
    end
  endtask

  // Expected outputs come from counting active steps: q = a mod M, wraps = a div M.
  task automatic test_runs();
    for (int r = 0; r < 10; r++) begin
      int mv, nw, m, a, c, pprob;
      bit act, prev_act, ended;
      logic [2:0] eq, et;
      logic [13:0] obs, exp_v;
      mv    = (r == 0) ? 6 : (r == 1) ? 0 : (r == 2) ? 12 : int'($urandom_range(0, 15));
      nw    = (r == 0) ? 2 : int'($urandom_range(1, 3));
      pprob = (r < 3) ? 0 : 30;
      m     = (mv < 2) ? 2 : (mv > 8) ? 8 : mv;
      cycle();
      bus.start = 1'b1; bus.mod_val = 4'(mv); bus.num_wraps = 4'(nw);
      cycle();
      bus.start = 1'b0; #1;
      n_tests++;
      if (bus.busy !== 1'b1 || bus.cnt_clr !== 1'b1 || bus.t !== 3'd0 || bus.wrap_cnt !== 4'd0) begin
        n_fail++;
        $display("FAIL run%0d clear_cycle busy=%b clr=%b t=%b wrap=%0d exp 1 1 000 0",
                 r, bus.busy, bus.cnt_clr, bus.t, bus.wrap_cnt);
      end
      a = 0; prev_act = 0; ended = 0; c = 2;
      while (!ended && c < 400) begin
        cycle();
        act = ($urandom_range(0, 99) >= pprob);
        bus.pause = !act; #1;
        eq = 3'(a % m);
        et = act ? (eq ^ 3'((a + 1) % m)) : 3'd0;
        exp_v = {eq, et, prev_act && (a > 0) && (a % m == 0), 1'b1, 1'b0, 1'b0, 4'((a / m) % 16)};
        obs   = {bus.q_in, bus.t, bus.tc, bus.busy, bus.done, bus.cnt_clr, bus.wrap_cnt};
        n_tests++;
        if (obs !== exp_v) begin
          n_fail++;
          $display("FAIL run%0d M=%0d cyc%0d {q,t,tc,busy,done,clr,wrap} got=%b exp=%b", r, m, c, obs, exp_v);
        end
        if (act) a++;
        prev_act = act;
        if (a == m * nw) ended = 1;
        c++;
      end
      bus.pause = 1'b0;
      if (!ended) begin
        n_tests++; n_fail++;
        $display("FAIL run%0d timeout got a=%0d exp %0d", r, a, m * nw);
      end
      cycle(); #1;
      obs   = {bus.q_in, bus.t, bus.tc, bus.busy, bus.done, bus.cnt_clr, bus.wrap_cnt};
      exp_v = {3'd0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'(nw)};
      n_tests++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL run%0d done_state got=%b exp=%b", r, obs, exp_v);
      end
      cycle(); #1;
      exp_v = {3'd0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 4'(nw)};
      obs   = {bus.q_in, bus.t, bus.tc, bus.busy, bus.done, bus.cnt_clr, bus.wrap_cnt};
      n_tests++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL run%0d done_pulse got=%b exp=%b", r, obs, exp_v);
      end
    end
  endtask

  task automatic test_free_run_abort();
    logic [10:0] obs, exp_v;
    cycle();
    bus.start = 1'b1; bus.mod_val = 4'd6; bus.num_wraps = 4'd0;
    cycle();
    bus.start = 1'b0;
    for (int k = 0; k < 40; k++) begin
      cycle(); #1;
      obs   = {bus.q_in, bus.tc, bus.busy, bus.done, bus.wrap_cnt, bus.cnt_clr};
      exp_v = {3'(k % 6), (k > 0) && (k % 6 == 0), 1'b1, 1'b0, 4'((k / 6) % 16), 1'b0};
      n_tests++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL free_run k=%0d got=%b exp=%b", k, obs, exp_v);
      end
    end
    cycle();
    bus.abort = 1'b1; #1;
    n_tests++;
    if (bus.t !== 3'd0 || bus.q_in !== 3'd4) begin
      n_fail++;
      $display("FAIL abort_cycle got t=%b q=%0d exp t=000 q=4", bus.t, bus.q_in);
    end
    cycle();
    bus.abort = 1'b0; #1;
    obs   = {bus.q_in, bus.tc, bus.busy, bus.done, bus.wrap_cnt, bus.cnt_clr};
    exp_v = {3'd4, 1'b0, 1'b0, 1'b0, 4'd6, 1'b1};
    n_tests++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL after_abort got=%b exp=%b", obs, exp_v);
    end
    cycle(); #1;
    n_tests++;
    if (bus.q_in !== 3'd0 || bus.done !== 1'b0 || bus.cnt_clr !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_cleared got q=%0d done=%b clr=%b exp 0 0 0", bus.q_in, bus.done, bus.cnt_clr);
    end
  endtask

  task automatic test_pause_hold();
    int a;
    bit act;
    logic [2:0] eq, et;
    cycle();
    bus.start = 1'b1; bus.mod_val = 4'd6; bus.num_wraps = 4'd1;
    cycle();
    bus.start = 1'b0;
    a = 0;
    for (int c = 2; c <= 15; c++) begin
      cycle();
      act = !(c >= 5 && c <= 9);
      bus.pause = (c >= 5 && c <= 9); #1;
      eq = (c <= 12) ? 3'(a % 6) : 3'd0;
      et = (act && c <= 12) ? (eq ^ 3'((a + 1) % 6)) : 3'd0;
      n_tests++;
      if (bus.q_in !== eq || bus.t !== et || bus.done !== (c == 14)) begin
        n_fail++;
        $display("FAIL pause_hold cyc%0d got q=%0d t=%b done=%b exp q=%0d t=%b done=%b",
                 c, bus.q_in, bus.t, bus.done, eq, et, (c == 14));
      end
      if (act && c <= 12) a++;
    end
    bus.pause = 1'b0;
  endtask

  task automatic test_out_of_range();
    cycle();
    bus.start = 1'b1; bus.mod_val = 4'd6; bus.num_wraps = 4'd0;
    cycle();
    bus.start = 1'b0;
    cycle(); cycle(); cycle();
    load_q = 1'b1; load_val = 3'd7;
    cycle();
    load_q = 1'b0; #1;
    n_tests++;
    if (bus.q_in !== 3'd7 || bus.t !== 3'b111 || bus.wrap_cnt !== 4'd0) begin
      n_fail++;
      $display("FAIL oor_force got q=%0d t=%b wrap=%0d exp 7 111 0", bus.q_in, bus.t, bus.wrap_cnt);
    end
    cycle(); #1;
    n_tests++;
    if (bus.q_in !== 3'd0 || bus.tc !== 1'b0 || bus.wrap_cnt !== 4'd0 || bus.t !== 3'b001) begin
      n_fail++;
      $display("FAIL oor_recover got q=%0d tc=%b wrap=%0d t=%b exp 0 0 0 001",
               bus.q_in, bus.tc, bus.wrap_cnt, bus.t);
    end
    bus.abort = 1'b1;
    cycle();
    bus.abort = 1'b0;
    cycle();
  endtask

  task automatic test_reset_mid_run();
    cycle();
    bus.start = 1'b1; bus.mod_val = 4'd5; bus.num_wraps = 4'd0;
    cycle();
    bus.start = 1'b0;
    for (int k = 0; k < 5; k++) cycle();
    #1;
    n_tests++;
    if (bus.q_in !== 3'd4) begin
      n_fail++;
      $display("FAIL rst_mid_pre got q=%0d exp 4", bus.q_in);
    end
    rst = 1'b1; bus.start = 1'b1; bus.pause = 1'b1; bus.abort = 1'b1;
    cycle();
    rst = 1'b0; bus.start = 1'b0; bus.pause = 1'b0; bus.abort = 1'b0; #1;
    n_tests++;
    if ({bus.busy, bus.tc, bus.done, bus.cnt_clr, bus.wrap_cnt} !== 8'b0001_0000 || bus.t !== 3'd0) begin
      n_fail++;
      $display("FAIL rst_mid_state got=%b t=%b exp=00010000 t=000",
               {bus.busy, bus.tc, bus.done, bus.cnt_clr, bus.wrap_cnt}, bus.t);
    end
    cycle();
    bus.start = 1'b1; bus.mod_val = 4'd3;
    cycle();
    bus.start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cycle(); #1;
      n_tests++;
      if (bus.q_in !== 3'(k % 3) || bus.tc !== (k == 3) || bus.done !== 1'b0) begin
        n_fail++;
        $display("FAIL rst_new_run k=%0d got q=%0d tc=%b done=%b exp q=%0d tc=%b done=0",
                 k, bus.q_in, bus.tc, bus.done, k % 3, (k == 3));
      end
    end
    bus.abort = 1'b1;
    cycle();
    bus.abort = 1'b0;
    cycle();
  endtask

  task automatic test_back_to_back();
    logic [6:0] exp_tab [2:6];
    logic [6:0] obs;
    exp_tab[2] = {1'b1, 1'b0, 1'b0, 1'b0, 3'd0};
    exp_tab[3] = {1'b1, 1'b0, 1'b0, 1'b0, 3'd1};
    exp_tab[4] = {1'b0, 1'b1, 1'b0, 1'b0, 3'd0};
    exp_tab[5] = {1'b0, 1'b0, 1'b1, 1'b0, 3'd0};
    exp_tab[6] = {1'b1, 1'b0, 1'b0, 1'b1, 3'd0};
    cycle();
    bus.start = 1'b1; bus.mod_val = 4'd2; bus.num_wraps = 4'd1;
    cycle();
    for (int c = 2; c <= 6; c++) begin
      cycle(); #1;
      obs = {bus.busy, bus.tc, bus.done, bus.cnt_clr, bus.q_in};
      n_tests++;
      if (obs !== exp_tab[c]) begin
        n_fail++;
        $display("FAIL back_to_back cyc%0d {busy,tc,done,clr,q} got=%b exp=%b", c, obs, exp_tab[c]);
      end
    end
    bus.start = 1'b0;
    for (int k = 0; k < 6; k++) cycle();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_runs();
    test_free_run_abort();
    test_pause_hold();
    test_out_of_range();
    test_reset_mid_run();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
